ecc_25_enc_stream: RTL

Streaming SECDED encoder for 25-bit words on the write side of the ECC-protected FIFO path. It accepts data on a valid/ready input and computes the 6-bit Hamming/SECDED parity. It presents registered data+parity on a valid/ready output toward the FIFO storage, whose read-side checker regenerates parity and decodes the syndrome. It also carries an optional one-shot error injector for exercising that checker in system.

---
 rtl/ecc_25_enc_stream.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ecc_25_enc_stream.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ecc_25_enc_stream
//
// Streaming SECDED encoder for 25-bit words on the write side of the
// ECC-protected FIFO path. Each accepted word gets a 6-bit Hamming/SECDED
// parity. Data and parity pass through a two-entry skid buffer (output
// register plus skid register) so that in_ready is driven straight from a flop.
//
// An optional one-shot error injector flips one or two codeword bits of the
// next accepted word. It lets the read-side checker be exercised in system.
// The injector is built only when the macro ECC25_ERR_INJ_EN is defined.
// Without the macro, the injector ports stay in place and have no effect.
//
// Codeword bit index: 0..24 = d0..d24, 25..30 = p0..p5.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   in_valid     input word valid
//   in_ready     input can accept (registered: skid register empty)
//   in_data      25-bit input word
//   out_valid    output word valid
//   out_ready    downstream accepts
//   out_data     stored data, possibly with injected flips
//   out_parity   parity of the pre-injection data, possibly with injected flips
//   inj_req      request one injection (sampled while idle)
//   inj_dbl      0 = single-bit flip, 1 = double-bit flip
//   inj_pos      first codeword bit to flip (31 = none)
//   inj_busy     injector armed
//   inj_done     one-cycle pulse after the injected word's input handshake
//   word_cnt     saturating count of output handshakes
// ----------------------------------------------------------------------------
module ecc_25_enc_stream #(
    parameter int DATA_WIDTH   = 25,
    parameter int PARITY_WIDTH = 6,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_parity,
    input  logic                    inj_req,
    input  logic                    inj_dbl,
    input  logic [4:0]              inj_pos,
    output logic                    inj_busy,
    output logic                    inj_done,
    output logic [CNT_WIDTH-1:0]    word_cnt
);

    localparam int CW_WIDTH = DATA_WIDTH + PARITY_WIDTH;

    // Data-bit coverage of each parity bit.
    localparam logic [24:0] P0_MASK = 25'h0AAAD5B;
    localparam logic [24:0] P1_MASK = 25'h133366D;
    localparam logic [24:0] P2_MASK = 25'h1C3C78E;
    localparam logic [24:0] P3_MASK = 25'h1FC07F0;
    localparam logic [24:0] P4_MASK = 25'h1FFF800;
    localparam logic [24:0] P5_MASK = 25'h1A65CB7;

    logic [PARITY_WIDTH-1:0] parity;
    logic [CW_WIDTH-1:0]     flip_mask;
    logic [CW_WIDTH-1:0]     in_cw;
    logic [CW_WIDTH-1:0]     out_q;
    logic [CW_WIDTH-1:0]     skid_q;
    logic                    out_valid_q;
    logic                    skid_valid_q;
    logic                    in_hs;
    logic                    out_hs;

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid_q & out_ready;

    always_comb begin
        parity[0] = ^(in_data & P0_MASK);
        parity[1] = ^(in_data & P1_MASK);
        parity[2] = ^(in_data & P2_MASK);
        parity[3] = ^(in_data & P3_MASK);
        parity[4] = ^(in_data & P4_MASK);
        parity[5] = ^(in_data & P5_MASK);
    end

    // Parity always comes from the clean word. Flips are applied afterwards.
    assign in_cw = {parity, in_data} ^ flip_mask;

`ifdef ECC25_ERR_INJ_EN
    typedef enum logic {IDLE, ARMED} inj_state_t;

    inj_state_t  state_q, state_d;
    logic        dbl_q;
    logic [4:0]  pos_q;
    logic        done_q;
    logic [4:0]  pos_next;
    logic [31:0] first_bit;
    logic [31:0] second_bit;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ARMED) && in_hs;
        end
    end

    // The request fields only matter while ARMED, and entry into ARMED always
    // reloads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && inj_req) begin
            dbl_q <= inj_dbl;
            pos_q <= inj_pos;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (inj_req) state_d = ARMED;
            ARMED:   if (in_hs)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The second flip wraps 30 -> 0. When the first position is 31 (no flip),
    // double mode lands on bit 0 as well.
    always_comb begin
        pos_next   = (pos_q >= 5'd30) ? 5'd0 : pos_q + 5'd1;
        first_bit  = 32'd1 << pos_q;
        second_bit = dbl_q ? (32'd1 << pos_next) : 32'd0;
        flip_mask  = '0;
        if (state_q == ARMED) begin
            flip_mask = first_bit[CW_WIDTH-1:0] ^ second_bit[CW_WIDTH-1:0];
        end
    end

    assign inj_busy = (state_q == ARMED);
    assign inj_done = done_q;
`else
    logic unused_inj;
    assign unused_inj = ^{inj_req, inj_dbl, inj_pos};
    assign flip_mask  = '0;
    assign inj_busy   = 1'b0;
    assign inj_done   = 1'b0;
`endif

    // Skid buffer. While the output register is empty or draining, it reloads,
    // taking the skid entry first to keep FIFO order. While it is stalled, a
    // new word parks in the skid register. in_ready is low whenever the skid
    // register is full, so the two can never be loaded in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_hs;
                if (in_hs) out_q <= in_cw;
            end
        end else if (in_hs) begin
            skid_valid_q <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset. Its valid flag alone decides whether
    // it is read, so clearing the flag discards the entry.
    always_ff @(posedge clk) begin
        if (out_valid_q && !out_ready && in_hs) skid_q <= in_cw;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (out_hs && word_cnt != {CNT_WIDTH{1'b1}}) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

    assign in_ready   = ~skid_valid_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_q[DATA_WIDTH-1:0];
    assign out_parity = out_q[CW_WIDTH-1:DATA_WIDTH];

endmodule
